adc_capture: RTL

ADC_CAPTURE -- requirements
Module: adc_capture

---
 rtl/adc_pkg.sv | 25 ++
 rtl/axis.sv | 14 +
 rtl/sdp_ram.sv | 33 +++
 rtl/adc_capture.sv | 126 ++++++++++++
 4 files changed

// File: rtl/adc_pkg.sv
// Shared types and helpers for the ADC capture block.
//   adc_state_e : capture FSM states
//   sat_abs     : saturating two's-complement magnitude, for component widths up to AbsW bits
package adc_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StSkipping,
    StCapture,
    StDone
  } adc_state_e;

  localparam int unsigned AbsW = 32;

  // x must already be sign-extended to AbsW bits; w is the true component width.
  // The most negative value maps to 2^(w-1)-1 so the result always fits w-1 magnitude bits.
  function automatic logic [AbsW-1:0] sat_abs(input logic [AbsW-1:0] x, input int unsigned w);
    logic [AbsW-1:0] lim;
    logic [AbsW-1:0] mag;
    lim = (AbsW'(1) << (w - 1)) - AbsW'(1);
    mag = x[AbsW-1] ? (~x + AbsW'(1)) : x;
    return (mag > lim) ? lim : mag;
  endfunction

endpackage

// File: rtl/axis.sv
// Minimal AXI-Stream interface (no backpressure sideband beyond tready).
//   tdata  : payload
//   tvalid : source has a beat
//   tready : sink can take a beat
interface axis #(
  parameter int unsigned WIDTH = 32
);
  logic [WIDTH-1:0] tdata;
  logic             tvalid;
  logic             tready;

  modport MST (output tdata, output tvalid, input tready);
  modport SLV (input tdata, input tvalid, output tready);
endinterface

// File: rtl/sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port, no reset on contents.
//   clk   : clock
//   we    : write enable, waddr/wdata : write address/data
//   re    : read enable, raddr : read address
//   rdata : registered read data (holds when re=0)
module sdp_ram #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 128
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/adc_capture.sv
// One-shot I/Q sample capture into a buffer with peak-magnitude tracking.
//   clk, rst  : clock, synchronous active-high reset
//   s_axis    : sample stream, tdata = {Q, I}, signed; never stalled (tready=~rst)
//   arm       : pulse to start a capture from IDLE or DONE
//   rd_addr, rd_en -> rd_data, rd_valid : buffer readout, one cycle latency
//   busy      : skipping or capturing
//   done      : capture complete, buffer stable
//   peak_i, peak_q : max saturated |I|, |Q| over stored samples
module adc_capture
  import adc_pkg::*;
#(
  parameter int unsigned TWID  = 16,
  parameter int unsigned DEPTH = 128,
  parameter int unsigned SKIP  = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  axis.SLV                         s_axis,
  input  logic                     arm,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  input  logic                     rd_en,
  output logic [2*TWID-1:0]        rd_data,
  output logic                     rd_valid,
  output logic                     busy,
  output logic                     done,
  output logic [TWID-1:0]          peak_i,
  output logic [TWID-1:0]          peak_q
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned SW = (SKIP > 1) ? $clog2(SKIP) : 1;
  // Wraps harmlessly when SKIP == 0; the skipping state is never entered then.
  localparam logic [SW-1:0] SkipLast = SW'(SKIP - 1);
  localparam logic [AW-1:0] LastIdx  = AW'(DEPTH - 1);

  adc_state_e      state;
  logic [SW-1:0]   skip_cnt;
  logic [AW-1:0]   wr_idx;
  logic            beat;
  logic            store;
  logic [TWID-1:0] abs_i;
  logic [TWID-1:0] abs_q;

  // The source cannot be stalled, so every valid beat outside reset is taken.
  assign s_axis.tready = ~rst;
  assign beat          = s_axis.tvalid & ~rst;
  assign store         = beat & (state == StCapture);

  assign abs_i = TWID'(sat_abs(AbsW'($signed(s_axis.tdata[TWID-1:0])), TWID));
  assign abs_q = TWID'(sat_abs(AbsW'($signed(s_axis.tdata[2*TWID-1:TWID])), TWID));

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= StIdle;
      skip_cnt <= '0;
      wr_idx   <= '0;
      peak_i   <= '0;
      peak_q   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      unique case (state)
        // A beat arriving with arm is dropped: the new capture starts on the next beat.
        StIdle, StDone: begin
          if (arm) begin
            skip_cnt <= '0;
            wr_idx   <= '0;
            peak_i   <= '0;
            peak_q   <= '0;
            busy     <= 1'b1;
            done     <= 1'b0;
            state    <= (SKIP > 0) ? StSkipping : StCapture;
          end
        end
        StSkipping: begin
          if (beat) begin
            if (skip_cnt == SkipLast) begin
              state <= StCapture;
            end else begin
              skip_cnt <= skip_cnt + SW'(1);
            end
          end
        end
        StCapture: begin
          if (beat) begin
            wr_idx <= wr_idx + AW'(1);
            if (abs_i > peak_i) peak_i <= abs_i;
            if (abs_q > peak_q) peak_q <= abs_q;
            if (wr_idx == LastIdx) begin
              state <= StDone;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        default: begin
          state <= StIdle;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
    end
  end

  sdp_ram #(
    .WIDTH (2 * TWID),
    .DEPTH (DEPTH)
  ) u_buf (
    .clk   (clk),
    .we    (store),
    .waddr (wr_idx),
    .wdata (s_axis.tdata),
    .re    (rd_en),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

endmodule
